// File: rtl/alu_arbiter_if.sv
// One requester's link to alu_arbiter: an operand/opcode request and a one-entry
// buffered ALU response, each with its own valid/ready handshake.
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_op;
  logic             req_ready;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_result;
  logic             resp_zero;
  logic             resp_ready;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one external 16-bit ALU between two requesters: one grant per cycle,
// round-robin or fixed priority, with a one-entry response buffer per requester.
module alu_arbiter #(
  parameter int WIDTH      = 16,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     req0_if,
  alu_arbiter_if.slave     req1_if,
  output logic [WIDTH-1:0] o_alu_in1,
  output logic [WIDTH-1:0] o_alu_in2,
  output logic [1:0]       o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_answer,
  input  logic             i_alu_zero,
  output logic [15:0]      o_ops_count
);

  logic             r_resp_valid0;
  logic             r_resp_valid1;
  logic [WIDTH-1:0] r_resp_result0;
  logic [WIDTH-1:0] r_resp_result1;
  logic             r_resp_zero0;
  logic             r_resp_zero1;
  logic             r_last_grant;
  logic [15:0]      r_ops_count;

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;

  // A full buffer being drained this cycle can accept a new result in the same cycle.
  // Readies are gated by rst_n so nothing is granted while reset is held.
  assign w_elig0 = rst_n && req0_if.req_valid && (!r_resp_valid0 || req0_if.resp_ready);
  assign w_elig1 = rst_n && req1_if.req_valid && (!r_resp_valid1 || req1_if.resp_ready);

  // On a tie requester 0 wins under fixed priority, or when requester 1 won last time.
  assign w_gnt0 = w_elig0 && (!w_elig1 || FIXED_PRIO || r_last_grant);
  assign w_gnt1 = w_elig1 && !w_gnt0;

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block infers a latch.
    o_alu_in1  = '0;
    o_alu_in2  = '0;
    o_alu_ctrl = 2'b00;
    if (w_gnt0) begin
      o_alu_in1  = req0_if.req_a;
      o_alu_in2  = req0_if.req_b;
      o_alu_ctrl = req0_if.req_op;
    end else if (w_gnt1) begin
      o_alu_in1  = req1_if.req_a;
      o_alu_in2  = req1_if.req_b;
      o_alu_ctrl = req1_if.req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid0  <= 1'b0;
      r_resp_valid1  <= 1'b0;
      r_resp_result0 <= '0;
      r_resp_result1 <= '0;
      r_resp_zero0   <= 1'b0;
      r_resp_zero1   <= 1'b0;
      r_last_grant   <= 1'b1;
      r_ops_count    <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments make every register sample pre-edge values,
      // so the result does not depend on statement order.
      if (w_gnt0) begin
        r_resp_valid0  <= 1'b1;
        r_resp_result0 <= i_alu_answer;
        r_resp_zero0   <= i_alu_zero;
      end else if (req0_if.resp_ready) begin
        r_resp_valid0  <= 1'b0;
      end

      if (w_gnt1) begin
        r_resp_valid1  <= 1'b1;
        r_resp_result1 <= i_alu_answer;
        r_resp_zero1   <= i_alu_zero;
      end else if (req1_if.resp_ready) begin
        r_resp_valid1  <= 1'b0;
      end

      if (w_gnt0 || w_gnt1) begin
        r_last_grant <= w_gnt1;
        r_ops_count  <= r_ops_count + 16'd1;
      end
    end
  end

  assign req0_if.req_ready   = w_gnt0;
  assign req1_if.req_ready   = w_gnt1;
  assign req0_if.resp_valid  = r_resp_valid0;
  assign req1_if.resp_valid  = r_resp_valid1;
  assign req0_if.resp_result = r_resp_result0;
  assign req1_if.resp_result = r_resp_result1;
  assign req0_if.resp_zero   = r_resp_zero0;
  assign req1_if.resp_zero   = r_resp_zero1;
  assign o_ops_count         = r_ops_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked by a
// spec-level model (grant rule, buffer occupancy, op count) and a response scoreboard.
module tb_alu_arbiter;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) rq0 ();
  alu_arbiter_if #(.WIDTH(WIDTH)) rq1 ();
  alu_arbiter_if #(.WIDTH(WIDTH)) fq0 ();
  alu_arbiter_if #(.WIDTH(WIDTH)) fq1 ();

  logic [WIDTH-1:0] alu_in1, alu_in2, alu_answer;
  logic [1:0]       alu_ctrl;
  logic             alu_zero;
  logic [15:0]      ops_count;
  logic [WIDTH-1:0] f_in1, f_in2, f_answer;
  logic [1:0]       f_ctrl;
  logic             f_zero;
  logic [15:0]      f_ops;

  // Behavioural ALU: returns {zero, result}.
  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                          input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_answer} = alu_f(alu_in1, alu_in2, alu_ctrl);
  assign {f_zero, f_answer}     = alu_f(f_in1, f_in2, f_ctrl);

  // The fixed-priority instance sees the same requests and always drains its responses.
  assign fq0.req_valid  = rq0.req_valid;
  assign fq0.req_a      = rq0.req_a;
  assign fq0.req_b      = rq0.req_b;
  assign fq0.req_op     = rq0.req_op;
  assign fq0.resp_ready = 1'b1;
  assign fq1.req_valid  = rq1.req_valid;
  assign fq1.req_a      = rq1.req_a;
  assign fq1.req_b      = rq1.req_b;
  assign fq1.req_op     = rq1.req_op;
  assign fq1.resp_ready = 1'b1;

  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .req0_if(rq0), .req1_if(rq1),
    .o_alu_in1(alu_in1), .o_alu_in2(alu_in2), .o_alu_ctrl(alu_ctrl),
    .i_alu_answer(alu_answer), .i_alu_zero(alu_zero), .o_ops_count(ops_count)
  );

  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req0_if(fq0), .req1_if(fq1),
    .o_alu_in1(f_in1), .o_alu_in2(f_in2), .o_alu_ctrl(f_ctrl),
    .i_alu_answer(f_answer), .i_alu_zero(f_zero), .o_ops_count(f_ops)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int               exp_last;
  logic             exp_rv [2];
  logic [15:0]      exp_ops;
  logic             acc [2];
  logic [WIDTH:0]   q0 [$];
  logic [WIDTH:0]   q1 [$];
  logic [WIDTH:0]   mon_e;

  task automatic model_reset();
    exp_last  = 1;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    exp_ops   = 16'd0;
    acc[0]    = 1'b0;
    acc[1]    = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    logic             v [2];
    logic             rr [2];
    logic             e [2];
    logic [WIDTH-1:0] a [2];
    logic [WIDTH-1:0] b [2];
    logic [1:0]       op [2];
    int               g;
    v[0] = rq0.req_valid;  rr[0] = rq0.resp_ready; a[0] = rq0.req_a; b[0] = rq0.req_b; op[0] = rq0.req_op;
    v[1] = rq1.req_valid;  rr[1] = rq1.resp_ready; a[1] = rq1.req_a; b[1] = rq1.req_b; op[1] = rq1.req_op;
    for (int i = 0; i < 2; i++) e[i] = v[i] && (!exp_rv[i] || rr[i]);
    if (e[0] && e[1])  g = (exp_last == 0) ? 1 : 0;
    else if (e[0])     g = 0;
    else if (e[1])     g = 1;
    else               g = -1;

    check("req0_ready", rq0.req_ready, g == 0);
    check("req1_ready", rq1.req_ready, g == 1);
    check("resp0_valid", rq0.resp_valid, exp_rv[0]);
    check("resp1_valid", rq1.resp_valid, exp_rv[1]);
    check("ops_count", ops_count, exp_ops);
    check("alu_in1", alu_in1, (g < 0) ? '0 : a[g]);
    check("alu_in2", alu_in2, (g < 0) ? '0 : b[g]);
    check("alu_ctrl", alu_ctrl, (g < 0) ? 2'b00 : op[g]);

    for (int i = 0; i < 2; i++) begin
      acc[i] = (g == i);
      if (g == i) begin
        exp_rv[i] = 1'b1;
        if (i == 0) q0.push_back(alu_f(a[i], b[i], op[i]));
        else        q1.push_back(alu_f(a[i], b[i], op[i]));
      end else if (rr[i]) begin
        exp_rv[i] = 1'b0;
      end
    end
    if (g >= 0) begin
      exp_last = g;
      exp_ops  = exp_ops + 16'd1;
    end
  endtask

  // Model checker: grants, occupancy, op count and ALU drive, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) model_step();
  end

  // Response monitor: every consumed response is compared against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (rq0.resp_valid && rq0.resp_ready) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp0_unexpected: got result 0x%0h expected no response", rq0.resp_result);
        end else begin
          mon_e = q0.pop_front();
          check("resp0_result", rq0.resp_result, mon_e[WIDTH-1:0]);
          check("resp0_zero", rq0.resp_zero, mon_e[WIDTH]);
        end
      end
      if (rq1.resp_valid && rq1.resp_ready) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL resp1_unexpected: got result 0x%0h expected no response", rq1.resp_result);
        end else begin
          mon_e = q1.pop_front();
          check("resp1_result", rq1.resp_result, mon_e[WIDTH-1:0]);
          check("resp1_zero", rq1.resp_zero, mon_e[WIDTH]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [1:0] op);
    if (i == 0) begin
      rq0.req_valid = v; rq0.req_a = a; rq0.req_b = b; rq0.req_op = op;
    end else begin
      rq1.req_valid = v; rq1.req_a = a; rq1.req_b = b; rq1.req_op = op;
    end
  endtask

  task automatic rand_req(input int i);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = WIDTH'($urandom);
    b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
    set_req(i, $urandom_range(0, 9) < 6, a, b, 2'($urandom_range(0, 3)));
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, 2'b00);
    set_req(1, 1'b0, '0, '0, 2'b00);
    rq0.resp_ready = 1'b1;
    rq1.resp_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_resp0_valid", rq0.resp_valid, 0);
    check("rst_resp1_result", rq1.resp_result, 0);
    check("rst_resp0_zero", rq0.resp_zero, 0);
    check("rst_ops_count", ops_count, 0);

    // Single ADD, ready in the same cycle, result one cycle later
    set_req(0, 1'b1, 16'h0003, 16'h0004, 2'b00);
    #1 check("add_ready_same_cycle", rq0.req_ready, 1);
    tick();
    set_req(0, 1'b0, '0, '0, 2'b00);
    check("add_resp_valid", rq0.resp_valid, 1);
    check("add_result", rq0.resp_result, 16'h0007);
    check("add_zero", rq0.resp_zero, 0);
    check("add_ops_count", ops_count, 1);

    // Zero flag from SUB and from ADD wrap-around
    set_req(1, 1'b1, 16'h1234, 16'h1234, 2'b01);
    tick();
    set_req(1, 1'b0, '0, '0, 2'b00);
    check("sub_result", rq1.resp_result, 16'h0000);
    check("sub_zero", rq1.resp_zero, 1);
    set_req(0, 1'b1, 16'hFFFF, 16'h0001, 2'b00);
    tick();
    check("wrap_result", rq0.resp_result, 16'h0000);
    check("wrap_zero", rq0.resp_zero, 1);

    // Logic ops, then idle ALU drive
    set_req(0, 1'b1, 16'hF0F0, 16'h0FF0, 2'b10);
    tick();
    check("and_result", rq0.resp_result, 16'h00F0);
    set_req(0, 1'b1, 16'hF0F0, 16'h0FF0, 2'b11);
    tick();
    check("or_result", rq0.resp_result, 16'hFFF0);
    set_req(0, 1'b0, '0, '0, 2'b00);
    #1;
    check("idle_alu_in1", alu_in1, 0);
    check("idle_alu_ctrl", alu_ctrl, 0);
    tick();

    // Back-pressure on requester 0, then drain+refill in one cycle
    set_req(0, 1'b1, 16'h0010, 16'h0001, 2'b01);
    tick();
    rq0.resp_ready = 1'b0;
    set_req(0, 1'b1, 16'h0100, 16'h0200, 2'b00);
    set_req(1, 1'b1, 16'h00AA, 16'h0055, 2'b11);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_req0_ready", rq0.req_ready, 0);
      check("bp_req1_ready", rq1.req_ready, 1);
      check("bp_resp0_hold", rq0.resp_result, 16'h000F);
      tick();
    end
    rq0.resp_ready = 1'b1;
    #1 check("refill_req0_ready", rq0.req_ready, 1);
    tick();
    set_req(0, 1'b0, '0, '0, 2'b00);
    set_req(1, 1'b0, '0, '0, 2'b00);
    check("refill_resp0_valid", rq0.resp_valid, 1);
    check("refill_resp0_result", rq0.resp_result, 16'h0300);
    tick();

    // Random traffic; an unaccepted request holds its operands
    for (int c = 0; c < 1500; c++) begin
      if (!(rq0.req_valid && !acc[0])) rand_req(0);
      if (!(rq1.req_valid && !acc[1])) rand_req(1);
      rq0.resp_ready = $urandom_range(0, 9) < 7;
      rq1.resp_ready = $urandom_range(0, 9) < 7;
      tick();
    end

    // Fresh reset, five ops on requester 1, leave its last response buffered
    set_req(0, 1'b0, '0, '0, 2'b00);
    set_req(1, 1'b0, '0, '0, 2'b00);
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    rq0.resp_ready = 1'b1;
    rq1.resp_ready = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      set_req(1, 1'b1, 16'(c), 16'h0001, 2'b00);
      tick();
    end
    set_req(1, 1'b0, '0, '0, 2'b00);
    rq1.resp_ready = 1'b0;
    tick();
    check("pre_rst_ops_count", ops_count, 5);
    check("pre_rst_resp1_valid", rq1.resp_valid, 1);

    // Asynchronous reset mid-stream with both requesters asking
    #2;
    set_req(0, 1'b1, 16'h0005, 16'h0006, 2'b11);
    set_req(1, 1'b1, 16'h0007, 16'h0008, 2'b01);
    rq1.resp_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_resp1_valid", rq1.resp_valid, 0);
    check("rst_mid_resp0_valid", rq0.resp_valid, 0);
    check("rst_mid_ops_count", ops_count, 0);
    check("rst_mid_req0_ready", rq0.req_ready, 0);
    check("rst_mid_req1_ready", rq1.req_ready, 0);
    check("rst_mid_alu_in1", alu_in1, 0);
    check("rst_mid_alu_ctrl", alu_ctrl, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Ties after reset: round-robin starts with 0, fixed priority always 0
    for (int c = 0; c < 4; c++) begin
      #1;
      check("rr_req0_ready", rq0.req_ready, (c % 2) == 0);
      check("rr_req1_ready", rq1.req_ready, (c % 2) == 1);
      check("fp_req0_ready", fq0.req_ready, 1);
      check("fp_req1_ready", fq1.req_ready, 0);
      tick();
    end
    check("fp_ops_count", f_ops, 4);
    check("fp_resp0_result", fq0.resp_result, 16'h0007);

    // Drain everything outstanding
    set_req(0, 1'b0, '0, '0, 2'b00);
    set_req(1, 1'b0, '0, '0, 2'b00);
    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares the single 16-bit ALU (ADD/SUB/AND/OR, 2-bit opcode, zero flag) between two requesters, e.g. the main datapath and a branch/address unit. Each cycle it grants at most one requester, which drives its operands and opcode onto the ALU. The combinational ALU answer and zero flag are captured into a per-requester one-entry response buffer with valid/ready handshake. Single issue per cycle, response latency of one cycle.

## Interface
- WIDTH, 16, datapath width; must equal the ALU operand width.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties.

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request present
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands (a -> ALU input1, b -> ALU input2)
- req0_op / req1_op  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR
- req0_ready / req1_ready  output  1  grant; request accepted when valid && ready
- resp0_valid / resp1_valid  output  1  response buffer holds a result
- resp0_result / resp1_result  output  WIDTH  captured ALU answer
- resp0_zero / resp1_zero  output  1  captured ALU zero flag
- resp0_ready / resp1_ready  input  1  requester consumes response
- alu_in1, alu_in2  output  WIDTH  to ALU operands
- alu_ctrl  output  2  to ALU opcode
- alu_answer  input  WIDTH  from ALU
- alu_zero  input  1  from ALU
- ops_count  output  16  number of accepted operations, wraps

## Operation
- Requester i is eligible when reqi_valid && (!respi_valid || respi_ready). A full buffer being drained in the same cycle may be refilled in that cycle.
- Grant selection is combinational:
  - Only one requester eligible: it is granted.
  - Both eligible, FIXED_PRIO=0: grant the requester other than last_grant.
  - Both eligible, FIXED_PRIO=1: grant requester 0.
  - None eligible: no grant.
- reqi_ready = granted_i. At most one ready is high per cycle. ready never depends on another cycle's state beyond the registered response and last_grant.
- ALU drive:
  - Granted: alu_in1/alu_in2/alu_ctrl = granted requester's a/b/op.
  - No grant: all zero (ctrl 00).
- On an accept edge for requester i:
  - respi_result <= alu_answer, respi_zero <= alu_zero, respi_valid <= 1.
  - last_grant <= i.
  - ops_count <= ops_count + 1, wrapping 0xFFFF -> 0x0000.
- Response drain: respi_valid && respi_ready with no refill clears respi_valid. result and zero hold their last values.
- Response drain with simultaneous refill: respi_valid stays 1 and the new result replaces the old one.
- Requester obligation: a, b and op stay stable while valid is high and not yet accepted. The arbiter latches nothing before accept.
- Arithmetic: all results are WIDTH-bit and modulo 2^WIDTH. SUB is input1 - input2, taken from the ALU. No carry or overflow is reported.
- Reset (async assert, sync-safe deassert):
  - resp*_valid = 0, resp*_result = 0, resp*_zero = 0, ops_count = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Reset mid-operation discards buffered responses. Requests must be re-presented.
- While rst_n is low, req*_ready = 0 and ALU outputs are zero.

## Timing
- Cycle N: request accepted (valid && ready at rising edge N+1). ALU is driven combinationally during cycle N.
- Cycle N+1: respi_valid = 1 with result. Latency is exactly 1 cycle.
- Throughput:
  - One operation per cycle in total.
  - A single requester with resp_ready held high is accepted every cycle.
  - Under contention with both eligible every cycle (round-robin), each requester gets every other cycle.
- Back-pressure: if respi_valid = 1 and respi_ready = 0, reqi_ready = 0 and the other requester may take the ALU that cycle.
- No combinational path from alu_answer to any ready signal. Ready depends only on req*_valid, resp*_ready and state.

## Test plan
- Single op, back-pressure: req0 ADD a=0x0003 b=0x0004, resp0_ready=1 -> req0_ready=1 same cycle; next cycle resp0_valid=1, result 0x0007, zero 0, ops_count 1.
- Zero flag and wrap: req1 SUB a=0x1234 b=0x1234 -> resp1_result 0x0000, zero 1. Then ADD 0xFFFF+0x0001 -> result 0x0000, zero 1.
- Tie, round-robin: both valid every cycle, FIXED_PRIO=0, resp*_ready=1 -> grants 0,1,0,1 starting with 0 after reset. With FIXED_PRIO=1 -> always 0.
- Back-pressure: resp0_ready=0 after one accept, req0 and req1 valid -> req0_ready=0, req1 granted each cycle, resp0 holds old result. Raising resp0_ready makes req0 eligible the same cycle (drain+refill), resp0_valid stays 1 with the new result.
- Logic ops and ALU drive: req0 AND 0xF0F0 & 0x0FF0 -> 0x00F0; OR -> 0xFFF0. While idle, alu_in1/alu_in2/alu_ctrl = 0.
- Reset mid-stream: assert rst_n=0 with resp1_valid=1 and ops_count=5 -> immediately resp*_valid=0, ops_count=0, readies 0. After release, tie goes to requester 0.
